// File: rtl/wbc_pkg.sv
// Shared constants and types for the writeback commit unit.
package wbc_pkg;

    localparam int REG_AW    = 5;
    localparam int WBC_DEPTH = 4;
    localparam int WBC_XLEN  = 32;

    localparam logic [REG_AW-1:0] X0 = '0;

    typedef struct packed {
        logic [REG_AW-1:0]   rd;
        logic [WBC_XLEN-1:0] data;
    } wbc_entry_t;

endpackage

// File: rtl/wbc_fifo.sv
// Load-result FIFO: storage, wrapping pointers, occupancy count,
// and a flat per-entry valid/rd view for the pending mask.
module wbc_fifo
    import wbc_pkg::*;
#(
    parameter int DEPTH = WBC_DEPTH,
    parameter int XLEN  = WBC_XLEN
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push_i,
    input  logic [REG_AW-1:0]        push_rd_i,
    input  logic [XLEN-1:0]          push_data_i,
    input  logic                     pop_i,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [REG_AW-1:0]        head_rd_o,
    output logic [XLEN-1:0]          head_data_o,
    output logic [DEPTH-1:0]         ent_valid_o,
    output logic [DEPTH*REG_AW-1:0]  ent_rd_o
);

    localparam int AW = $clog2(DEPTH);

    logic [AW-1:0]     rptr_q;
    logic [AW-1:0]     wptr_q;
    logic [AW:0]       cnt_q;
    logic [AW:0]       cnt_d;
    logic [REG_AW-1:0] rd_q   [DEPTH];
    logic [XLEN-1:0]   data_q [DEPTH];
    logic              do_push;
    logic              do_pop;

    assign full_o  = (cnt_q == (AW+1)'(DEPTH));
    assign empty_o = (cnt_q == '0);
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;

    assign head_rd_o   = rd_q[rptr_q];
    assign head_data_o = data_q[rptr_q];

    always_comb begin
        cnt_d = cnt_q;
        unique case ({do_push, do_pop})
            2'b10:   cnt_d = cnt_q + 1'b1;
            2'b01:   cnt_d = cnt_q - 1'b1;
            default: cnt_d = cnt_q;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rptr_q <= '0;
            wptr_q <= '0;
            cnt_q  <= '0;
        end else begin
            if (do_push) wptr_q <= wptr_q + 1'b1;
            if (do_pop)  rptr_q <= rptr_q + 1'b1;
            cnt_q <= cnt_d;
        end
    end

    // Payload is qualified by the occupancy, so it needs no reset.
    always_ff @(posedge clk) begin
        if (do_push) begin
            rd_q[wptr_q]   <= push_rd_i;
            data_q[wptr_q] <= push_data_i;
        end
    end

    for (genvar g = 0; g < DEPTH; g++) begin : g_ent
        logic [AW-1:0] off;
        assign off = AW'(g) - rptr_q;
        assign ent_valid_o[g] = ({1'b0, off} < cnt_q);
        assign ent_rd_o[g*REG_AW +: REG_AW] = rd_q[g];
    end

endmodule

// File: rtl/wb_commit_unit.sv
// Writeback commit unit: ALU beats win the regfile port, buffered loads drain otherwise.
// Define WBC_FWD_EN to drive fwd_* from the registered write; else they read 0.
module wb_commit_unit
    import wbc_pkg::*;
#(
    parameter int DEPTH = WBC_DEPTH,
    parameter int XLEN  = WBC_XLEN
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              alu_valid,
    input  logic [4:0]        alu_rd,
    input  logic [XLEN-1:0]   alu_data,
    input  logic              ld_valid,
    output logic              ld_ready,
    input  logic [4:0]        ld_rd,
    input  logic [XLEN-1:0]   ld_data,
    output logic              we,
    output logic [4:0]        wb_addr,
    output logic [XLEN-1:0]   wb_data,
    output logic [31:0]       pending,
    output logic              fwd_valid,
    output logic [4:0]        fwd_addr,
    output logic [XLEN-1:0]   fwd_data
);

    logic                    rdy_q;
    logic                    we_q,   we_d;
    logic [REG_AW-1:0]       addr_q, addr_d;
    logic [XLEN-1:0]         data_q, data_d;
    logic                    alu_live;
    logic                    push;
    logic                    pop;
    logic                    full;
    logic                    empty;
    logic [REG_AW-1:0]       head_rd;
    logic [XLEN-1:0]         head_data;
    logic [DEPTH-1:0]        ent_valid;
    logic [DEPTH*REG_AW-1:0] ent_rd;

    assign alu_live = alu_valid && (alu_rd != X0);
    assign ld_ready = rdy_q && !full;
    assign push     = ld_valid && ld_ready && (ld_rd != X0);
    assign pop      = !alu_live && !empty;

    wbc_fifo #(
        .DEPTH (DEPTH),
        .XLEN  (XLEN)
    ) u_fifo (
        .clk         (clk),
        .reset       (reset),
        .push_i      (push),
        .push_rd_i   (ld_rd),
        .push_data_i (ld_data),
        .pop_i       (pop),
        .full_o      (full),
        .empty_o     (empty),
        .head_rd_o   (head_rd),
        .head_data_o (head_data),
        .ent_valid_o (ent_valid),
        .ent_rd_o    (ent_rd)
    );

    always_comb begin
        we_d   = 1'b0;
        addr_d = addr_q;
        data_d = data_q;
        unique case (1'b1)
            alu_live: begin
                we_d   = 1'b1;
                addr_d = alu_rd;
                data_d = alu_data;
            end
            pop: begin
                we_d   = 1'b1;
                addr_d = head_rd;
                data_d = head_data;
            end
            default: ;
        endcase
    end

    // ld_ready is held low until the first edge after reset release.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rdy_q  <= 1'b0;
            we_q   <= 1'b0;
            addr_q <= '0;
            data_q <= '0;
        end else begin
            rdy_q  <= 1'b1;
            we_q   <= we_d;
            addr_q <= addr_d;
            data_q <= data_d;
        end
    end

    always_comb begin
        pending = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (ent_valid[i]) pending[ent_rd[i*REG_AW +: REG_AW]] = 1'b1;
        end
        pending[0] = 1'b0;
    end

    assign we      = we_q;
    assign wb_addr = addr_q;
    assign wb_data = data_q;

`ifdef WBC_FWD_EN
    assign fwd_valid = we_q;
    assign fwd_addr  = addr_q;
    assign fwd_data  = data_q;
`else
    assign fwd_valid = 1'b0;
    assign fwd_addr  = '0;
    assign fwd_data  = '0;
`endif

endmodule
